// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DEPTH  = 256;

  // Length field arrives low byte first.
  localparam bit FRAME_LITTLE_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // A frame length is usable only if it is non-zero and fits in the memory.
  function automatic logic len_ok(input logic [15:0] len, input int unsigned depth);
    return (len != 16'd0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_dp.sv
// Loader datapath: address/byte counters, length register and running XOR checksum.
module imem_loader_dp
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              len_lo_we,
  input  logic              len_we,
  input  logic              data_inc,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W:0]   len_val,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   byte_cnt,
  output logic [7:0]        len_lo,
  output logic [7:0]        csum,
  output logic              last_c
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      byte_cnt <= '0;
      len_lo   <= '0;
      len      <= '0;
      csum     <= '0;
    end else if (clr) begin
      addr     <= '0;
      byte_cnt <= '0;
      len_lo   <= '0;
      len      <= '0;
      csum     <= '0;
    end else begin
      if (len_lo_we) len_lo <= rx_data;
      if (len_we)    len    <= len_val;
      // Address wraps naturally after a full-depth image.
      if (data_inc) begin
        addr     <= addr + ADDR_W'(1);
        byte_cnt <= byte_cnt + CNT_W'(1);
        csum     <= csum ^ rx_data;
      end
    end
  end

  assign last_c = ((byte_cnt + CNT_W'(1)) == len);

endmodule

// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: frame FSM, handshake, write port and CPU hold.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              xfer_c;
  logic              clr_c, len_lo_we_c, len_we_c, data_inc_c;
  logic [15:0]       full_len_c;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic              last_c;

  assign xfer_c     = rx_valid & rx_ready;
  assign full_len_c = FRAME_LITTLE_ENDIAN ? {rx_data, len_lo} : {len_lo, rx_data};

  imem_loader_dp #(.ADDR_W(ADDR_W)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_c),
    .len_lo_we (len_lo_we_c),
    .len_we    (len_we_c),
    .data_inc  (data_inc_c),
    .rx_data   (rx_data),
    .len_val   (CNT_W'(full_len_c)),
    .addr      (addr),
    .byte_cnt  (byte_cnt),
    .len_lo    (len_lo),
    .csum      (csum),
    .last_c    (last_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clr_c       = 1'b0;
    len_lo_we_c = 1'b0;
    len_we_c    = 1'b0;
    data_inc_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          clr_c   = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (xfer_c) begin
          len_lo_we_c = 1'b1;
          state_d     = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer_c) begin
          len_we_c = 1'b1;
          state_d  = len_ok(full_len_c, DEPTH) ? ST_DATA : ST_ERR;
        end
      end
      ST_DATA: begin
        if (xfer_c) begin
          data_inc_c = 1'b1;
          if (last_c) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (xfer_c) state_d = (rx_data == csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      rx_ready <= (state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM});
      cpu_hold <= !(state_d inside {ST_IDLE, ST_DONE});
      done     <= (state_d == ST_DONE);
      error    <= (state_d == ST_ERR);
      mem_we   <= data_inc_c;
      if (data_inc_c) begin
        mem_waddr <= addr;
        mem_wdata <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random frames against a frame-level reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW = IMEM_ADDR_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, mem_we, cpu_hold, done, error;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW:0]   byte_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [AW+7:0] exp_q[$];
  logic [7:0]    payload[$];
  logic [7:0]    imem[IMEM_DEPTH];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .byte_cnt  (byte_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && mem_we === 1'b1) begin
        imem[mem_waddr] = mem_wdata;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", mem_waddr, mem_wdata);
        end else begin
          chk("write", 32'({mem_waddr, mem_wdata}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_payload, input logic [AW-1:0] a, input int gap);
    int budget;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    budget   = 0;
    while (rx_ready !== 1'b1 && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (rx_ready !== 1'b1) begin
      nvec++;
      nerr++;
      $display("FAIL rx_ready_timeout: byte 0x%0h never accepted", b);
    end else if (is_payload) begin
      exp_q.push_back({a, b});
    end
    @(negedge clk); #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("start_hold",  32'(cpu_hold), 1);
    chk("start_ready", 32'(rx_ready), 1);
    chk("start_done",  32'(done),     0);
    chk("start_error", 32'(error),    0);
    chk("start_cnt",   32'(byte_cnt), 0);
  endtask

  function automatic int gap_of(input bit gaps);
    return gaps ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Reference: a frame succeeds iff 1<=len<=DEPTH and the checksum is the XOR of the payload.
  task automatic run_frame(input logic [15:0] len16, input bit bad_csum, input bit gaps, input int start_at);
    logic [7:0] x;
    bit ok, good;
    x  = 8'h00;
    ok = (len16 != 16'd0) && (int'(len16) <= int'(IMEM_DEPTH));
    do_start();
    send_byte(len16[7:0],  1'b0, '0, gap_of(gaps));
    send_byte(len16[15:8], 1'b0, '0, gap_of(gaps));
    if (ok) begin
      foreach (payload[i]) begin
        x ^= payload[i];
        if (i == start_at) start = 1'b1;
        send_byte(payload[i], 1'b1, AW'(i), gap_of(gaps));
      end
      send_byte(bad_csum ? ~x : x, 1'b0, '0, gap_of(gaps));
    end
    good = ok && !bad_csum;
    chk("end_done",  32'(done),     32'(good));
    chk("end_error", 32'(error),    32'(!good));
    chk("end_hold",  32'(cpu_hold), 32'(!good));
    chk("end_ready", 32'(rx_ready), 0);
    chk("end_cnt",   32'(byte_cnt), ok ? 32'(len16) : 0);
    repeat (3) @(negedge clk);
    #1;
    chk("writes_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic rand_payload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] word;
    foreach (imem[i]) imem[i] = 8'h00;

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(rx_ready),  0);
    chk("rst_hold",  32'(cpu_hold),  0);
    chk("rst_we",    32'(mem_we),    0);
    chk("rst_waddr", 32'(mem_waddr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_flags", 32'({done, error}), 0);
    chk("rst_cnt",   32'(byte_cnt),  0);
    reset = 1'b1;
    @(negedge clk); #1;

    // Short program; fetch word at 0 is little-endian.
    payload = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_frame(16'd4, 1'b0, 1'b0, -1);
    word = {payload[3], payload[2], payload[1], payload[0]};
    chk("fetch_word0", {imem[3], imem[2], imem[1], imem[0]}, word);

    // Full-depth image.
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    run_frame(16'd256, 1'b0, 1'b0, -1);
    chk("full_last", 32'(imem[255]), 32'hFF);
    chk("full_first", 32'(imem[0]), 32'h00);

    // Illegal lengths.
    payload.delete();
    run_frame(16'h0000, 1'b0, 1'b0, -1);
    run_frame(16'h0101, 1'b0, 1'b0, -1);
    run_frame(16'h0200, 1'b0, 1'b0, -1);

    // Bad checksum, then recovery.
    payload = '{8'hAA, 8'h55};
    run_frame(16'd2, 1'b1, 1'b0, -1);
    rand_payload(5);
    run_frame(16'd5, 1'b0, 1'b0, -1);

    // Source gaps and a stray start during DATA.
    rand_payload(12);
    run_frame(16'd12, 1'b0, 1'b1, 5);

    // Reset in the middle of a payload.
    rand_payload(8);
    do_start();
    send_byte(8'd8, 1'b0, '0, 0);
    send_byte(8'd0, 1'b0, '0, 0);
    for (int i = 0; i < 3; i++) send_byte(payload[i], 1'b1, AW'(i), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rx_ready), 0);
    chk("mid_rst_hold",  32'(cpu_hold), 0);
    chk("mid_rst_we",    32'(mem_we),   0);
    chk("mid_rst_flags", 32'({done, error}), 0);
    chk("mid_rst_cnt",   32'(byte_cnt), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_drained", 32'(exp_q.size()), 0);
    run_frame(16'd8, 1'b0, 1'b0, -1);

    // Random frames.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 40));
      rand_payload(n);
      run_frame(16'(n), ($urandom_range(0, 3) == 0), 1'b1, int'($urandom_range(0, 45)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-serial programming controller for the 256-byte instruction memory, which is byte-addressed and assembles each 32-bit word little-endian from four consecutive bytes.
- Accepts a framed image from a byte source (UART receiver or debug link) over a valid/ready handshake.
- Writes the payload bytes sequentially from address 0 and verifies an XOR checksum.
- Holds the CPU in stall for the whole load, so fetch never sees a partial image.

Parameters:
- ADDR_W, 8, byte-address width of the instruction memory.
- DEPTH, 256, memory size in bytes (must equal 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  byte write strobe to the instruction memory.
- mem_waddr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- cpu_hold  output  1  stall/hold request to the CPU (PC frozen, no fetch).
- done  output  1  last load completed with a good checksum (level).
- error  output  1  last load failed (level).
- byte_cnt  output  ADDR_W+1  payload bytes written so far in the current load.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit payload length, little-endian), then LEN payload bytes, then a CSUM byte equal to the XOR of all payload bytes.
- A transfer occurs on any rising edge where rx_valid and rx_ready are both 1.
- States and transitions:
  - IDLE -> LEN_LO on start.
  - LEN_LO -> LEN_HI on transfer.
  - LEN_HI -> DATA on transfer if 1 <= len <= DEPTH; otherwise -> ERR.
  - DATA -> CSUM on the transfer of the final payload byte.
  - CSUM -> DONE on transfer if the received byte equals the running XOR; otherwise -> ERR.
  - DONE or ERR -> LEN_LO on start.
- rx_ready: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in IDLE, DONE and ERR.
- Payload writes:
  - Each DATA transfer produces mem_we=1 on the following cycle, with mem_waddr equal to the current address counter and mem_wdata equal to the byte. Write latency is exactly 1 cycle.
  - mem_we is otherwise 0; mem_waddr and mem_wdata hold their last value.
  - The address counter starts at 0 for each load and increments per payload byte.
  - len=256 fills addresses 0..255; the counter wraps to 0 after the last byte, but no write to address 0 follows.
- Length is stored in 9 bits: len = {LEN_HI, LEN_LO}. Any value >256, or 0, goes to ERR with no memory writes.
- The running XOR and byte_cnt clear on entry to LEN_LO. byte_cnt increments with each payload transfer.
- cpu_hold:
  - Goes to 1 on the cycle after start is accepted.
  - Stays at 1 through ERR: the image is invalid, and the CPU is released only by a successful reload or by reset.
  - Goes to 0 on entry to DONE. The final write has already committed at that point, because CSUM consumes at least one cycle.
- done and error: done=1 only in DONE, error=1 only in ERR, and both clear on entry to LEN_LO.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM. A start arriving in the same cycle as a transfer is ignored.
- Stalled source: with rx_valid=0 the state, counters and outputs hold indefinitely. There is no timeout.
- Reset: asynchronous assert, from any state including mid-load. All outputs and registers go to:
  - state IDLE
  - cpu_hold 0 (the CPU runs the power-on image)
  - rx_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0
  - done 0, error 0, byte_cnt 0
- After reset mid-load, the memory contents are partially overwritten; recovery requires a new start.
- Memory write port: the instruction memory gains a synchronous byte-write port driven by mem_we, mem_waddr and mem_wdata. The combinational read path is unchanged.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR; 3 bits);
  - IMEM_ADDR_W = 8 and IMEM_DEPTH = 256, shared with the instruction memory;
  - the frame byte-order convention (little-endian).
- One natural sub-module, imem_loader_dp: address counter, byte counter, length register and XOR accumulator, with clear/increment controls from the FSM.
- The FSM and handshake logic stay in the top level.

Test Plan:
- Load len=4, bytes 0x13,0x00,0x00,0x00, csum 0x13 -> four writes (addr 0..3, one cycle after each transfer), done=1, cpu_hold 1->0, byte_cnt=4; fetch at address 0 returns 0x00000013.
- Load len=256, bytes i for i=0..255, csum 0x00 -> 256 writes, last write at addr 0xFF, no extra write, byte_cnt=256, done=1.
- Length 0x0000 or 0x0101 -> ERR after LEN_HI, no mem_we, error=1, cpu_hold=1, rx_ready=0.
- len=2, bytes 0xAA,0x55, csum 0x00 (correct is 0xFF) -> both writes occur, error=1, cpu_hold stays 1; a following good load clears error and drops cpu_hold.
- Random rx_valid gaps and a start pulse during DATA -> same writes as the gap-free case, start ignored, state unaffected.
- reset low for 1 cycle after 3 of 8 payload bytes -> immediate IDLE, cpu_hold=0, mem_we=0, done=error=0, byte_cnt=0; a fresh start loads normally.
